// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: FSM encoding, instruction size,
// opcode field position and the default reset PC.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 21;
    localparam int          OPCODE_WIDTH     = OPCODE_MSB - OPCODE_LSB + 1;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: sequential PC+4 or redirect target, plus the
// alignment check applied to redirect targets only.
module instruction_fetch_pc_next
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  misaligned
);

    // Sequential increment wraps naturally at the address width.
    always_comb begin
        next_pc    = pc + ADDR_WIDTH'(INSTR_BYTES);
        misaligned = 1'b0;
        if (branch_taken) begin
            next_pc    = branch_target;
            misaligned = !is_word_aligned(branch_target[1:0]);
        end else begin
            next_pc    = pc + ADDR_WIDTH'(INSTR_BYTES);
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues requests to a variable-latency instruction
// memory, holds the fetched word for decode and counts retired instructions.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    COUNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_ready,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             instr,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    instr_valid,
    input  logic                    advance,
    input  logic                    branch_taken,
    input  logic [ADDR_WIDTH-1:0]   branch_target,
    output logic [COUNT_WIDTH-1:0]  retired_count,
    output logic                    misalign_fault
);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
    logic                   imem_req_q, imem_req_d;
    logic [31:0]            instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [COUNT_WIDTH-1:0] retired_count_q, retired_count_d;
    logic                   misalign_fault_q, misalign_fault_d;

    logic [ADDR_WIDTH-1:0]  next_pc_s;
    logic                   misaligned_s;

    instruction_fetch_pc_next #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc_s),
        .misaligned    (misaligned_s)
    );

    // Next-state and register updates; anything not touched in a state holds.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        imem_addr_d      = imem_addr_q;
        imem_req_d       = imem_req_q;
        instr_d          = instr_q;
        instr_valid_d    = instr_valid_q;
        retired_count_d  = retired_count_q;
        misalign_fault_d = misalign_fault_q;

        case (state_q)
            ST_IDLE: begin
                state_d     = ST_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    instr_valid_d   = 1'b0;
                    retired_count_d = retired_count_q + COUNT_WIDTH'(1'b1);
                    // A misaligned redirect keeps pc on the faulting instruction.
                    if (misaligned_s) begin
                        misalign_fault_d = 1'b1;
                        state_d          = ST_FAULT;
                    end else begin
                        pc_d        = next_pc_s;
                        imem_addr_d = next_pc_s;
                        imem_req_d  = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FAULT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                state_d       = ST_FAULT;
            end
            default: begin
                state_d       = ST_IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pc_q             <= RESET_PC;
            imem_addr_q      <= RESET_PC;
            imem_req_q       <= 1'b0;
            instr_q          <= 32'h0;
            instr_valid_q    <= 1'b0;
            retired_count_q  <= '0;
            misalign_fault_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            imem_addr_q      <= imem_addr_d;
            imem_req_q       <= imem_req_d;
            instr_q          <= instr_d;
            instr_valid_q    <= instr_valid_d;
            retired_count_q  <= retired_count_d;
            misalign_fault_q <= misalign_fault_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc             = pc_q;
    assign instr_valid    = instr_valid_q;
    assign retired_count  = retired_count_q;
    assign misalign_fault = misalign_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; a second instance with a 3-bit
// retired counter shares all inputs so counter wrap is reachable quickly.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] pc;
    logic        instr_valid;
    logic        advance;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] retired_count;
    logic        misalign_fault;

    logic        w_imem_req;
    logic [63:0] w_imem_addr;
    logic [31:0] w_instr;
    logic [10:0] w_opcode;
    logic [63:0] w_pc;
    logic        w_instr_valid;
    logic [2:0]  w_retired_count;
    logic        w_misalign_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .opcode(opcode), .pc(pc), .instr_valid(instr_valid), .advance(advance),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .retired_count(retired_count), .misalign_fault(misalign_fault)
    );

    instruction_fetch #(.COUNT_WIDTH(3)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(w_instr),
        .opcode(w_opcode), .pc(w_pc), .instr_valid(w_instr_valid), .advance(advance),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .retired_count(w_retired_count), .misalign_fault(w_misalign_fault)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a request, then answers after 'waits' idle cycles.
    task automatic serve(input int waits, input logic [31:0] data, output int low);
        int guard;
        low   = 0;
        guard = 0;
        while (!imem_req && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL serve_req_timeout got %b want 1", imem_req);
        end
        if (!instr_valid) low++;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (!instr_valid) low++;
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic step_advance(input logic br, input logic [63:0] tgt);
        advance       = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        tick();
        advance       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (pc !== 64'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", pc); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (retired_count !== 32'h0) begin n_bad++; $display("FAIL rst_count got %h want 0", retired_count); end
        n_cmp++; if (misalign_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", misalign_fault); end
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL idle_req got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL idle_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_first_fetch();
        int low;
        serve(0, 32'h8B02_0020, low);
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid got %b want 1", instr_valid); end
        n_cmp++; if (opcode !== 11'h458) begin n_bad++; $display("FAIL t1_opcode got %h want 458", opcode); end
        n_cmp++; if (instr !== 32'h8B02_0020) begin n_bad++; $display("FAIL t1_instr got %h want 8b020020", instr); end
        n_cmp++; if (pc !== 64'h0) begin n_bad++; $display("FAIL t1_pc got %h want 0", pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t1_req got %b want 0", imem_req); end
    endtask

    task automatic test_ignored_inputs();
        imem_ready    = 1'b1;
        imem_rdata    = 32'hFFFF_FFFF;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        tick();
        tick();
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        n_cmp++; if (instr !== 32'h8B02_0020) begin n_bad++; $display("FAIL ign_instr got %h want 8b020020", instr); end
        n_cmp++; if (pc !== 64'h0) begin n_bad++; $display("FAIL ign_pc got %h want 0", pc); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ign_valid got %b want 1", instr_valid); end
        n_cmp++; if (retired_count !== 32'h0) begin n_bad++; $display("FAIL ign_count got %h want 0", retired_count); end
    endtask

    task automatic test_sequential();
        int low;
        step_advance(1'b0, 64'h0);
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t2_req got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 64'h4) begin n_bad++; $display("FAIL t2_addr got %h want 4", imem_addr); end
        n_cmp++; if (pc !== 64'h4) begin n_bad++; $display("FAIL t2_pc got %h want 4", pc); end
        n_cmp++; if (retired_count !== 32'h1) begin n_bad++; $display("FAIL t2_count got %h want 1", retired_count); end
        serve(3, 32'h9100_0421, low);
        n_cmp++; if (low !== 4) begin n_bad++; $display("FAIL t2_low_cycles got %0d want 4", low); end
        n_cmp++; if (opcode !== 11'h488) begin n_bad++; $display("FAIL t2_opcode got %h want 488", opcode); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL t2_valid got %b want 1", instr_valid); end
    endtask

    task automatic test_branch();
        int low;
        step_advance(1'b1, 64'h100);
        n_cmp++; if (imem_addr !== 64'h100) begin n_bad++; $display("FAIL t3_addr got %h want 100", imem_addr); end
        n_cmp++; if (pc !== 64'h100) begin n_bad++; $display("FAIL t3_pc got %h want 100", pc); end
        n_cmp++; if (retired_count !== 32'h2) begin n_bad++; $display("FAIL t3_count got %h want 2", retired_count); end
        serve(1, 32'hD65F_03C0, low);
        n_cmp++; if (low !== 2) begin n_bad++; $display("FAIL t3_low_cycles got %0d want 2", low); end
        n_cmp++; if (opcode !== 11'h6B2) begin n_bad++; $display("FAIL t3_opcode got %h want 6b2", opcode); end
    endtask

    task automatic test_misalign();
        step_advance(1'b1, 64'h102);
        n_cmp++; if (misalign_fault !== 1'b1) begin n_bad++; $display("FAIL t4_fault got %b want 1", misalign_fault); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t4_req got %b want 0", imem_req); end
        n_cmp++; if (pc !== 64'h100) begin n_bad++; $display("FAIL t4_pc got %h want 100", pc); end
        n_cmp++; if (retired_count !== 32'h3) begin n_bad++; $display("FAIL t4_count got %h want 3", retired_count); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL t4_valid got %b want 0", instr_valid); end
        advance       = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        imem_ready    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        advance       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_ready    = 1'b0;
        n_cmp++; if (misalign_fault !== 1'b1) begin n_bad++; $display("FAIL t4_sticky got %b want 1", misalign_fault); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t4_req_held got %b want 0", imem_req); end
        n_cmp++; if (retired_count !== 32'h3) begin n_bad++; $display("FAIL t4_count_held got %h want 3", retired_count); end
        n_cmp++; if (pc !== 64'h100) begin n_bad++; $display("FAIL t4_pc_held got %h want 100", pc); end
        do_reset();
        n_cmp++; if (misalign_fault !== 1'b0) begin n_bad++; $display("FAIL t4_cleared got %b want 0", misalign_fault); end
    endtask

    task automatic test_wrap();
        int low;
        tick();
        serve(0, 32'h8B02_0020, low);
        step_advance(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL t5_top_addr got %h want fffffffffffffffc", imem_addr); end
        serve(0, 32'h8B02_0020, low);
        step_advance(1'b0, 64'h0);
        n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL t5_wrap_addr got %h want 0", imem_addr); end
        n_cmp++; if (pc !== 64'h0) begin n_bad++; $display("FAIL t5_wrap_pc got %h want 0", pc); end
        n_cmp++; if (retired_count !== 32'h2) begin n_bad++; $display("FAIL t5_count got %h want 2", retired_count); end
        for (int k = 3; k <= 8; k++) begin
            serve(0, 32'h9100_0421, low);
            step_advance(1'b0, 64'h0);
            if (k == 7) begin
                n_cmp++; if (w_retired_count !== 3'd7) begin n_bad++; $display("FAIL t5_small_max got %0d want 7", w_retired_count); end
            end
        end
        n_cmp++; if (w_retired_count !== 3'd0) begin n_bad++; $display("FAIL t5_small_wrap got %0d want 0", w_retired_count); end
        n_cmp++; if (retired_count !== 32'h8) begin n_bad++; $display("FAIL t5_count8 got %h want 8", retired_count); end
        n_cmp++; if (pc !== 64'h18) begin n_bad++; $display("FAIL t5_pc got %h want 18", pc); end
    endtask

    task automatic test_reset_mid_fetch();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t6_pre_req got %b want 1", imem_req); end
        reset = 1'b1;
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t6_req_dropped got %b want 0", imem_req); end
        reset      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL t6_instr got %h want 0", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL t6_valid got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t6_req got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL t6_addr got %h want 0", imem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL t6_valid_later got %b want 0", instr_valid); end
    endtask

    initial begin
        reset         = 1'b1;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        advance       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_ignored_inputs();
        test_sequential();
        test_branch();
        test_misalign();
        test_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
